// File: rtl/pb_debouncer_array.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability counter,
// debounced level and one-cycle press / release / long-press strobes.
module pb_debouncer_array #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int HOLD_W     = 20,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] PB_state,
  output logic [N_CH-1:0] PB_down,
  output logic [N_CH-1:0] PB_up,
  output logic [N_CH-1:0] PB_long
);

  localparam logic POL = (ACTIVE_LOW != 0);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic              r_s1;
      logic              r_s2;
      logic              r_state;
      logic              r_down;
      logic              r_up;
      logic              r_long;
      logic              r_fired;
      logic [CNT_W-1:0]  r_cnt;
      logic [HOLD_W-1:0] r_hcnt;
      logic              w_p;
      logic              w_diff;
      logic              w_cnt_full;
      logic              w_hcnt_full;

      assign w_p         = PB[gi] ^ POL;
      assign w_diff      = (r_s2 != r_state);
      assign w_cnt_full  = &r_cnt;
      assign w_hcnt_full = &r_hcnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_state <= 1'b0;
          r_cnt   <= '0;
          r_hcnt  <= '0;
          r_fired <= 1'b0;
          r_down  <= 1'b0;
          r_up    <= 1'b0;
          r_long  <= 1'b0;
        end else begin
          r_s1   <= w_p;
          r_s2   <= r_s1;
          r_down <= 1'b0;
          r_up   <= 1'b0;
          r_long <= 1'b0;

          // Any return to the accepted level restarts the count from zero.
          if (!w_diff) begin
            r_cnt <= '0;
          end else if (!w_cnt_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= r_s2;
            r_cnt   <= '0;
            r_down  <= r_s2;
            r_up    <= ~r_s2;
          end

          // Released state (including the accepting edge) keeps the hold timer cleared.
          if (!r_state) begin
            r_hcnt  <= '0;
            r_fired <= 1'b0;
          end else if (!r_fired) begin
            if (w_hcnt_full) begin
              r_long  <= 1'b1;
              r_fired <= 1'b1;
            end else begin
              r_hcnt <= r_hcnt + HOLD_W'(1);
            end
          end
        end
      end

      assign PB_state[gi] = r_state;
      assign PB_down[gi]  = r_down;
      assign PB_up[gi]    = r_up;
      assign PB_long[gi]  = r_long;
    end
  endgenerate

endmodule

// File: tb/tb_pb_debouncer_array.sv
// Scoreboard bench: an active-high and an active-low instance are driven together and
// their strobes are checked against a sample-window reference model.
`timescale 1ns/1ps
module tb_pb_debouncer_array;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 3;
  localparam int HOLD_W = 4;
  localparam int NK     = 2 * N_CH;
  localparam int STAB   = 1 << CNT_W;
  localparam int HOLD   = 1 << HOLD_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] pb_h = '1;
  logic [N_CH-1:0] pb_l = '1;
  logic [N_CH-1:0] st_h, dn_h, up_h, lg_h;
  logic [N_CH-1:0] st_l, dn_l, up_l, lg_l;

  always #10 clk = ~clk;

  pb_debouncer_array #(.N_CH(N_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .ACTIVE_LOW(0)) u_dut_h (
    .clk(clk), .rst(rst), .PB(pb_h),
    .PB_state(st_h), .PB_down(dn_h), .PB_up(up_h), .PB_long(lg_h)
  );

  pb_debouncer_array #(.N_CH(N_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .ACTIVE_LOW(1)) u_dut_l (
    .clk(clk), .rst(rst), .PB(pb_l),
    .PB_state(st_l), .PB_down(dn_l), .PB_up(up_l), .PB_long(lg_l)
  );

  typedef struct {
    int edge_no;
    int k;
    int kind;   // 0 down, 1 up, 2 long
  } ev_t;

  ev_t sbq[$];
  int  edge_n = 0;
  int  n_cmp  = 0;
  int  n_err  = 0;

  // Reference model: bit j of win is the pressed level sampled j edges ago.
  logic [STAB+1:0] win     [NK];
  logic            m_state [NK];
  logic            m_fired [NK];
  int              age     [NK];

  function automatic string kname(int kind);
    return (kind == 0) ? "down" : (kind == 1) ? "up" : "long";
  endfunction

  task automatic push_ev(int k, int kind);
    ev_t e;
    e.edge_no = edge_n;
    e.k       = k;
    e.kind    = kind;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < NK; k++) begin
      logic p;
      logic v;
      bit   dn, upv, lg;
      dn = 0; upv = 0; lg = 0;
      if (rst) begin
        win[k]     = '0;
        m_state[k] = 1'b0;
        m_fired[k] = 1'b0;
        age[k]     = 0;
      end else begin
        p      = (k < N_CH) ? pb_h[k] : ~pb_l[k-N_CH];
        win[k] = {win[k][STAB:0], p};
        v      = win[k][2];
        if (m_state[k] && !m_fired[k]) begin
          age[k]++;
          if (age[k] == HOLD) begin
            lg         = 1;
            m_fired[k] = 1'b1;
          end
        end
        // Accept a new level once STAB consecutive synchronised samples agree on it.
        if (m_state[k] != v && win[k][STAB+1:2] == {STAB{v}}) begin
          m_state[k] = v;
          if (v) begin
            dn         = 1;
            age[k]     = 0;
            m_fired[k] = 1'b0;
          end else begin
            upv = 1;
          end
        end
        if (dn)  push_ev(k, 0);
        if (upv) push_ev(k, 1);
        if (lg)  push_ev(k, 2);
      end
    end
  end

  always @(negedge clk) begin
    logic [NK-1:0] sv, ms;
    logic [NK-1:0] strobes [3];
    ev_t           e;
    sv         = {st_l, st_h};
    strobes[0] = {dn_l, dn_h};
    strobes[1] = {up_l, up_h};
    strobes[2] = {lg_l, lg_h};
    for (int k = 0; k < NK; k++) ms[k] = m_state[k];

    n_cmp++;
    if (sv !== ms) begin
      n_err++;
      $display("FAIL state @edge %0d: got %b want %b", edge_n, sv, ms);
    end

    for (int k = 0; k < NK; k++) begin
      for (int kind = 0; kind < 3; kind++) begin
        if (strobes[kind][k] === 1'b1) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL strobe ch%0d %s @edge %0d: got pulse want none", k, kname(kind), edge_n);
          end else begin
            e = sbq.pop_front();
            if (e.edge_no != edge_n || e.k != k || e.kind != kind) begin
              n_err++;
              $display("FAIL strobe ch%0d %s @edge %0d: want ch%0d %s @edge %0d",
                       k, kname(kind), edge_n, e.k, kname(e.kind), e.edge_no);
            end
          end
        end else if (strobes[kind][k] !== 1'b0) begin
          n_cmp++;
          n_err++;
          $display("FAIL strobe ch%0d %s @edge %0d: got %b want 0/1", k, kname(kind), edge_n, strobes[kind][k]);
        end
      end
    end

    while (sbq.size() > 0 && sbq[0].edge_no <= edge_n) begin
      e = sbq.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing ch%0d %s: got no pulse want pulse @edge %0d", e.k, kname(e.kind), e.edge_no);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lvl(int k, logic lvl);
    if (k < N_CH) pb_h[k] = lvl;
    else          pb_l[k-N_CH] = ~lvl;
  endtask

  initial begin
    int   dur [NK];
    logic lvl [NK];

    // Reset with active-high buttons all pressed and active-low buttons idle.
    tick(3);
    rst = 1'b0;
    tick(20);

    pb_h = '0;
    tick(15);
    pb_h[0] = 1'b1;                       // clean press
    tick(15);
    for (int i = 0; i < 10; i++) begin    // bouncing channel
      pb_h[1] = ~pb_h[1];
      tick(3);
    end
    pb_h[1] = 1'b1;
    tick(15);
    pb_h[2] = 1'b1;                       // long press then release
    tick(40);
    pb_h[2] = 1'b0;
    tick(15);
    pb_h[3] = 1'b1;                       // short press
    tick(12);
    pb_h[3] = 1'b0;
    tick(15);

    pb_l[0] = 1'b0;                       // active-low press, reset mid-count
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(30);
    pb_l[0] = 1'b1;
    tick(15);

    for (int k = 0; k < NK; k++) begin
      dur[k] = 1;
      lvl[k] = 1'b0;
    end
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < NK; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          lvl[k] = ~lvl[k];
          set_lvl(k, lvl[k]);
          dur[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end

    rst  = 1'b0;
    pb_h = '0;
    pb_l = '1;
    tick(60);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending events want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
